// File: rtl/tdc_multistop_control.sv
// tdc_multistop_control: configures a TDC over a byte-wide SPI master, then
// fires periodic multi-stop shots and streams tagged result words to a FIFO.
module tdc_multistop_control #(
  parameter int unsigned SHOOT_PERIOD  = 5000000,
  parameter int unsigned NUM_STOPS     = 1,
  parameter int unsigned TRIG_DELAY    = 5,
  parameter int unsigned START_WIDTH   = 3,
  parameter int unsigned INTB_TIMEOUT  = 65535,
  parameter logic [1:0]  CALIB_PERIODS = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        pause,
  input  logic        tdc_intb,
  input  logic        spi_busy,
  input  logic [7:0]  spi_miso,
  output logic        spi_start,
  output logic [7:0]  spi_mosi,
  output logic        spi_cs_end,
  output logic        tdc_start,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_data,
  output logic [15:0] timeout_cnt,
  output logic        running
);

  if (NUM_STOPS < 1 || NUM_STOPS > 5) begin : g_bad_num_stops
    $error("NUM_STOPS must be in 1..5");
  end
  if (SHOOT_PERIOD < 2 || TRIG_DELAY < 2 || START_WIDTH < 1 || INTB_TIMEOUT < 1) begin : g_bad_timing
    $error("SHOOT_PERIOD/TRIG_DELAY must be >= 2, START_WIDTH/INTB_TIMEOUT >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_SHOT_WAIT, S_ARM, S_TRIG, S_PULSE,
    S_INTB_WAIT, S_READ, S_CALC, S_PUSH
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic        r_pend, w_pend_nxt;
  logic        r_spi_start, w_spi_start_nxt, r_spi_start_d;
  logic [7:0]  r_spi_mosi, w_spi_mosi_nxt;
  logic        r_spi_cs_end, w_spi_cs_end_nxt;
  logic        r_tdc_start, w_tdc_start_nxt;
  logic [23:0] r_rdata, w_rdata_nxt;
  logic [2:0]  r_k, w_k_nxt;
  logic [23:0] r_time [0:4];
  logic [23:0] r_cal1, w_cal1_nxt, r_cal2, w_cal2_nxt, r_diff, w_diff_nxt;
  logic [2:0]  r_push_idx, w_push_idx_nxt;
  logic        r_to_flag, w_to_flag_nxt;
  logic        r_wr_req, w_wr_req_nxt;
  logic [31:0] r_fifo_data, w_fifo_data_nxt;
  logic [15:0] r_timeout_cnt, w_timeout_cnt_nxt;
  logic        r_running, w_running_nxt;
  logic        r_intb_s1, r_intb_s2;

  logic        w_txn_active, w_txn_wr, w_txn_fin, w_byte_done, w_time_we, w_push_last;
  logic [5:0]  w_txn_addr;
  logic [7:0]  w_txn_wdata;
  logic [23:0] w_rd_word;
  logic [31:0] w_push_word;

  // A byte ends on the first idle-busy cycle that is neither the start cycle nor the one after it.
  assign w_byte_done  = r_pend & ~r_spi_start & ~r_spi_start_d & ~spi_busy;
  assign w_rd_word    = {r_rdata[15:0], spi_miso};
  assign w_txn_active = (r_state == S_CFG) || (r_state == S_ARM) || (r_state == S_READ);

  // Register transaction selected by the current state (direction, address, write data).
  always_comb begin
    w_txn_wr    = 1'b0;
    w_txn_addr  = 6'h00;
    w_txn_wdata = 8'h00;
    case (r_state)
      S_CFG: begin
        w_txn_wr    = 1'b1;
        w_txn_addr  = 6'h01;
        w_txn_wdata = {CALIB_PERIODS, 3'b000, 3'(NUM_STOPS - 1)};
      end
      S_ARM: begin
        w_txn_wr    = 1'b1;
        w_txn_addr  = 6'h00;
        w_txn_wdata = 8'h01;
      end
      S_READ: begin
        if (r_k < 3'(NUM_STOPS)) begin
          w_txn_addr = 6'h10 + {2'b00, r_k, 1'b0};
        end else if (r_k == 3'(NUM_STOPS)) begin
          w_txn_addr = 6'h1B;
        end else begin
          w_txn_addr = 6'h1C;
        end
      end
      default: begin
        w_txn_wr = 1'b0;
      end
    endcase
  end

  // Word to push next: timeout marker, tagged stop time, or calibration difference.
  always_comb begin
    w_push_word = 32'h0000_0000;
    w_push_last = 1'b0;
    if (r_to_flag) begin
      w_push_word = {4'hE, 28'h000_0000};
      w_push_last = 1'b1;
    end else if (r_push_idx < 3'(NUM_STOPS)) begin
      w_push_word = {1'b0, r_push_idx, 4'h0, r_time[r_push_idx]};
    end else begin
      w_push_word = {4'hF, 4'h0, r_diff};
      w_push_last = 1'b1;
    end
  end

  // Next-state and datapath logic: SPI byte engine plus the shot sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_byte_idx_nxt    = r_byte_idx;
    w_pend_nxt        = r_pend;
    w_spi_start_nxt   = 1'b0;
    w_spi_mosi_nxt    = r_spi_mosi;
    w_spi_cs_end_nxt  = r_spi_cs_end;
    w_tdc_start_nxt   = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_k_nxt           = r_k;
    w_cal1_nxt        = r_cal1;
    w_cal2_nxt        = r_cal2;
    w_diff_nxt        = r_diff;
    w_push_idx_nxt    = r_push_idx;
    w_to_flag_nxt     = r_to_flag;
    w_wr_req_nxt      = r_wr_req;
    w_fifo_data_nxt   = r_fifo_data;
    w_timeout_cnt_nxt = r_timeout_cnt;
    w_running_nxt     = r_running;
    w_time_we         = 1'b0;
    w_txn_fin         = 1'b0;

    if (w_txn_active) begin
      if (!r_pend) begin
        w_spi_start_nxt = 1'b1;
        w_pend_nxt      = 1'b1;
        if (r_byte_idx == 2'd0) begin
          w_spi_mosi_nxt = {1'b0, w_txn_wr, w_txn_addr};
        end else if (w_txn_wr) begin
          w_spi_mosi_nxt = w_txn_wdata;
        end else begin
          w_spi_mosi_nxt = 8'h00;
        end
        w_spi_cs_end_nxt = w_txn_wr ? (r_byte_idx == 2'd1) : (r_byte_idx == 2'd3);
      end else if (w_byte_done) begin
        w_pend_nxt = 1'b0;
        if (!w_txn_wr && (r_byte_idx != 2'd0)) begin
          w_rdata_nxt = w_rd_word;
        end else begin
          w_rdata_nxt = r_rdata;
        end
        if (r_spi_cs_end) begin
          w_byte_idx_nxt = 2'd0;
          w_txn_fin      = 1'b1;
        end else begin
          w_byte_idx_nxt = r_byte_idx + 2'd1;
        end
      end else begin
        w_pend_nxt = r_pend;
      end
    end else begin
      w_pend_nxt = r_pend;
    end

    case (r_state)
      S_IDLE: begin
        if (init_req) begin
          w_byte_idx_nxt = 2'd0;
          w_state_nxt    = S_CFG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CFG: begin
        if (w_txn_fin) begin
          w_running_nxt = 1'b1;
          w_cnt_nxt     = 32'd0;
          w_state_nxt   = S_SHOT_WAIT;
        end else begin
          w_state_nxt = S_CFG;
        end
      end
      S_SHOT_WAIT: begin
        if (r_cnt == 32'(SHOOT_PERIOD - 1)) begin
          if (!pause) begin
            w_cnt_nxt   = 32'd0;
            w_state_nxt = S_ARM;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_ARM: begin
        if (w_txn_fin) begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = S_TRIG;
        end else begin
          w_state_nxt = S_ARM;
        end
      end
      S_TRIG: begin
        // Launch one cycle early so the registered START edge lands TRIG_DELAY cycles after the write.
        if (r_cnt == 32'(TRIG_DELAY - 2)) begin
          w_cnt_nxt       = 32'd0;
          w_tdc_start_nxt = 1'b1;
          w_state_nxt     = S_PULSE;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_PULSE: begin
        if (r_cnt == 32'(START_WIDTH - 1)) begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = S_INTB_WAIT;
        end else begin
          w_tdc_start_nxt = 1'b1;
          w_cnt_nxt       = r_cnt + 32'd1;
        end
      end
      S_INTB_WAIT: begin
        if (!r_intb_s2) begin
          w_k_nxt        = 3'd0;
          w_byte_idx_nxt = 2'd0;
          w_cnt_nxt      = 32'd0;
          w_state_nxt    = S_READ;
        end else if (r_cnt == 32'(INTB_TIMEOUT - 1)) begin
          if (r_timeout_cnt == 16'hFFFF) begin
            w_timeout_cnt_nxt = r_timeout_cnt;
          end else begin
            w_timeout_cnt_nxt = r_timeout_cnt + 16'd1;
          end
          w_to_flag_nxt  = 1'b1;
          w_push_idx_nxt = 3'd0;
          w_cnt_nxt      = 32'd0;
          w_state_nxt    = S_PUSH;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_READ: begin
        if (w_txn_fin) begin
          w_k_nxt = r_k + 3'd1;
          if (r_k < 3'(NUM_STOPS)) begin
            w_time_we = 1'b1;
          end else if (r_k == 3'(NUM_STOPS)) begin
            w_cal1_nxt = w_rd_word;
          end else begin
            w_cal2_nxt  = w_rd_word;
            w_state_nxt = S_CALC;
          end
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_CALC: begin
        w_diff_nxt     = r_cal2 - r_cal1;
        w_push_idx_nxt = 3'd0;
        w_to_flag_nxt  = 1'b0;
        w_state_nxt    = S_PUSH;
      end
      S_PUSH: begin
        if (!r_wr_req) begin
          w_fifo_data_nxt = w_push_word;
          w_wr_req_nxt    = 1'b1;
        end else if (!fifo_full) begin
          w_wr_req_nxt = 1'b0;
          if (w_push_last) begin
            w_to_flag_nxt = 1'b0;
            w_cnt_nxt     = 32'd0;
            w_state_nxt   = S_SHOT_WAIT;
          end else begin
            w_push_idx_nxt = r_push_idx + 3'd1;
          end
        end else begin
          w_wr_req_nxt = r_wr_req;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any shot and clears all strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      r_byte_idx    <= 2'd0;
      r_pend        <= 1'b0;
      r_spi_start   <= 1'b0;
      r_spi_start_d <= 1'b0;
      r_spi_mosi    <= 8'h00;
      r_spi_cs_end  <= 1'b0;
      r_tdc_start   <= 1'b0;
      r_rdata       <= 24'h0;
      r_k           <= 3'd0;
      r_cal1        <= 24'h0;
      r_cal2        <= 24'h0;
      r_diff        <= 24'h0;
      r_push_idx    <= 3'd0;
      r_to_flag     <= 1'b0;
      r_wr_req      <= 1'b0;
      r_fifo_data   <= 32'h0;
      r_timeout_cnt <= 16'h0;
      r_running     <= 1'b0;
      r_intb_s1     <= 1'b1;
      r_intb_s2     <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_byte_idx    <= w_byte_idx_nxt;
      r_pend        <= w_pend_nxt;
      r_spi_start   <= w_spi_start_nxt;
      r_spi_start_d <= r_spi_start;
      r_spi_mosi    <= w_spi_mosi_nxt;
      r_spi_cs_end  <= w_spi_cs_end_nxt;
      r_tdc_start   <= w_tdc_start_nxt;
      r_rdata       <= w_rdata_nxt;
      r_k           <= w_k_nxt;
      r_cal1        <= w_cal1_nxt;
      r_cal2        <= w_cal2_nxt;
      r_diff        <= w_diff_nxt;
      r_push_idx    <= w_push_idx_nxt;
      r_to_flag     <= w_to_flag_nxt;
      r_wr_req      <= w_wr_req_nxt;
      r_fifo_data   <= w_fifo_data_nxt;
      r_timeout_cnt <= w_timeout_cnt_nxt;
      r_running     <= w_running_nxt;
      r_intb_s1     <= tdc_intb;
      r_intb_s2     <= r_intb_s1;
    end
  end

  // Stop-time capture registers, loaded as each TIMEn read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        r_time[i] <= 24'h0;
      end
    end else if (w_time_we) begin
      r_time[r_k] <= w_rd_word;
    end
  end

  assign spi_start   = r_spi_start;
  assign spi_mosi    = r_spi_mosi;
  assign spi_cs_end  = r_spi_cs_end;
  assign tdc_start   = r_tdc_start;
  // The request is held in a register; the strobe is gated so no write ever lands while full.
  assign fifo_wr_en  = r_wr_req & ~fifo_full;
  assign fifo_data   = r_fifo_data;
  assign timeout_cnt = r_timeout_cnt;
  assign running     = r_running;

endmodule

// File: tb/tb_tdc_multistop_control.sv
// Directed bench for tdc_multistop_control: SPI slave/TDC model, FIFO monitor,
// hand-computed expected bytes and words.
module tb_tdc_multistop_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_req = 1'b0;
  logic        pause = 1'b0;
  logic        tdc_intb = 1'b1;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_miso = 8'h00;
  logic        spi_start, spi_cs_end, tdc_start, fifo_wr_en, running;
  logic [7:0]  spi_mosi;
  logic        fifo_full = 1'b0;
  logic [31:0] fifo_data;
  logic [15:0] timeout_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  log_mosi [$];
  logic        log_cs   [$];
  logic [31:0] fifo_q   [$];
  int          n_reads = 0;

  logic [23:0] t1 = 24'h000123, t2 = 24'h000456, t3 = 24'h000789;
  logic [23:0] cal1 = 24'h000100, cal2 = 24'h001100;
  logic        no_intb = 1'b0;
  logic        full_arm = 1'b0;
  logic        pause_drop = 1'b0;

  tdc_multistop_control #(
    .SHOOT_PERIOD(10), .NUM_STOPS(3), .TRIG_DELAY(5), .START_WIDTH(3),
    .INTB_TIMEOUT(20), .CALIB_PERIODS(2'd0)
  ) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .pause(pause), .tdc_intb(tdc_intb),
    .spi_busy(spi_busy), .spi_miso(spi_miso), .spi_start(spi_start), .spi_mosi(spi_mosi),
    .spi_cs_end(spi_cs_end), .tdc_start(tdc_start), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .timeout_cnt(timeout_cnt), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] reg_val(input logic [5:0] a);
    case (a)
      6'h10:   return t1;
      6'h12:   return t2;
      6'h14:   return t3;
      6'h1B:   return cal1;
      6'h1C:   return cal2;
      default: return 24'h0;
    endcase
  endfunction

  // SPI slave, TDC interrupt and FIFO model, all acting on the falling edge.
  initial begin
    int cyc = 0, busy_cnt = 0, byte_pos = 0, c_arm_done = 0, rise_cyc = 0, full_cnt = 0;
    logic [7:0]  cur_cmd = 8'h00;
    logic        cur_cs = 1'b0, tdc_prev = 1'b0, full_done = 1'b0;
    logic [23:0] v;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        spi_busy = 1'b0; busy_cnt = 0; byte_pos = 0; tdc_prev = 1'b0;
      end else begin
        if (fifo_wr_en) begin
          chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
          fifo_q.push_back(fifo_data);
        end
        if (full_cnt > 0) begin
          full_cnt--;
          if (full_cnt == 0) fifo_full = 1'b0;
        end
        if (fifo_wr_en && full_arm && !full_done) begin
          fifo_full = 1'b1; full_cnt = 7; pause = 1'b1; full_done = 1'b1;
        end
        if (pause_drop) pause = 1'b0;

        if (tdc_start && !tdc_prev) begin
          rise_cyc = cyc;
          chk("trig_delay", 32'(cyc - c_arm_done), 32'd5);
        end
        if (!tdc_start && tdc_prev) chk("start_width", 32'(cyc - rise_cyc), 32'd3);
        tdc_prev = tdc_start;
        if (tdc_start && !no_intb) tdc_intb = 1'b0;

        if (spi_start) begin
          chk("one_outstanding", {31'd0, spi_busy}, 32'd0);
          log_mosi.push_back(spi_mosi);
          log_cs.push_back(spi_cs_end);
          if (byte_pos == 0) begin
            cur_cmd = spi_mosi;
            spi_miso = 8'h00;
            if (spi_mosi[6] == 1'b0) begin
              n_reads++;
              tdc_intb = 1'b1;
            end
          end else begin
            v = reg_val(cur_cmd[5:0]);
            case (byte_pos)
              1:       spi_miso = v[23:16];
              2:       spi_miso = v[15:8];
              default: spi_miso = v[7:0];
            endcase
          end
          cur_cs = spi_cs_end;
          byte_pos = spi_cs_end ? 0 : byte_pos + 1;
          spi_busy = 1'b1;
          busy_cnt = 3;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            spi_busy = 1'b0;
            if (cur_cs && cur_cmd == 8'h40) c_arm_done = cyc;
          end
        end
      end
    end
  end

  task automatic wait_words(input int n, input int budget);
    int i = 0;
    while (fifo_q.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk($sformatf("wait_words_%0d", n), {31'd0, fifo_q.size() >= n}, 32'd1);
  endtask

  // Main directed sequence.
  initial begin
    int i, snap;
    logic [31:0] exp_w [0:3];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_start", {31'd0, spi_start}, 32'd0);
    chk("rst_spi_mosi", {24'd0, spi_mosi}, 32'd0);
    chk("rst_cs_end", {31'd0, spi_cs_end}, 32'd0);
    chk("rst_tdc_start", {31'd0, tdc_start}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_fifo_data", fifo_data, 32'd0);
    chk("rst_timeout_cnt", {16'd0, timeout_cnt}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_spi", 32'(log_mosi.size()), 32'd0);
    chk("idle_running", {31'd0, running}, 32'd0);

    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    i = 0;
    while (!running && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("cfg_running", {31'd0, running}, 32'd1);
    chk("cfg_nbytes", 32'(log_mosi.size()), 32'd2);
    chk("cfg_cmd", {24'd0, log_mosi[0]}, 32'h41);
    chk("cfg_cmd_cs", {31'd0, log_cs[0]}, 32'd0);
    chk("cfg_data", {24'd0, log_mosi[1]}, 32'h02);
    chk("cfg_data_cs", {31'd0, log_cs[1]}, 32'd1);

    exp_w[0] = 32'h00000123; exp_w[1] = 32'h10000456;
    exp_w[2] = 32'h20000789; exp_w[3] = 32'hF0001000;

    // Shot 1: normal three-stop shot.
    wait_words(4, 800);
    chk("arm_cmd", {24'd0, log_mosi[2]}, 32'h40);
    chk("arm_cmd_cs", {31'd0, log_cs[2]}, 32'd0);
    chk("arm_data", {24'd0, log_mosi[3]}, 32'h01);
    chk("arm_data_cs", {31'd0, log_cs[3]}, 32'd1);
    chk("rd_time1_cmd", {24'd0, log_mosi[4]}, 32'h10);
    chk("rd_dummy", {24'd0, log_mosi[5]}, 32'h00);
    chk("rd_dummy2_cs", {31'd0, log_cs[6]}, 32'd0);
    chk("rd_last_cs", {31'd0, log_cs[7]}, 32'd1);
    chk("rd_time2_cmd", {24'd0, log_mosi[8]}, 32'h12);
    chk("rd_time3_cmd", {24'd0, log_mosi[12]}, 32'h14);
    chk("rd_cal1_cmd", {24'd0, log_mosi[16]}, 32'h1B);
    chk("rd_cal2_cmd", {24'd0, log_mosi[20]}, 32'h1C);
    for (int k = 0; k < 4; k++) chk($sformatf("shot1_w%0d", k), fifo_q[k], exp_w[k]);

    // Shot 2: calibration difference wraps modulo 2^24.
    cal1 = 24'hFFFFF0; cal2 = 24'h000010;
    wait_words(8, 800);
    for (int k = 0; k < 3; k++) chk($sformatf("shot2_w%0d", k), fifo_q[4 + k], exp_w[k]);
    chk("shot2_wrap", fifo_q[7], 32'hF0000020);

    // Shot 3: INTB never asserts.
    no_intb = 1'b1;
    snap = n_reads;
    wait_words(9, 800);
    chk("timeout_word", fifo_q[8], 32'hE0000000);
    @(posedge clk); #1;
    chk("timeout_cnt", {16'd0, timeout_cnt}, 32'd1);
    chk("timeout_no_reads", 32'(n_reads), 32'(snap));
    no_intb = 1'b0;
    cal1 = 24'h000100; cal2 = 24'h001100;

    // Shot 4: the shot after a timeout runs normally.
    wait_words(13, 800);
    for (int k = 0; k < 4; k++) chk($sformatf("shot4_w%0d", k), fifo_q[9 + k], exp_w[k]);

    // Shot 5: FIFO back-pressure and pause raised mid-shot.
    full_arm = 1'b1;
    wait_words(17, 800);
    for (int k = 0; k < 4; k++) chk($sformatf("shot5_w%0d", k), fifo_q[13 + k], exp_w[k]);
    chk("pause_is_high", {31'd0, pause}, 32'd1);
    snap = log_mosi.size();
    repeat (60) @(posedge clk);
    #1;
    chk("paused_no_arm", 32'(log_mosi.size()), 32'(snap));
    chk("paused_words", 32'(fifo_q.size()), 32'd17);
    pause_drop = 1'b1;
    i = 0;
    while (log_mosi.size() == snap && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    chk("resume_started", {31'd0, log_mosi.size() > snap}, 32'd1);
    if (log_mosi.size() > snap) chk("resume_arm_cmd", {24'd0, log_mosi[snap]}, 32'h40);
    chk("still_running", {31'd0, running}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
